// File: rtl/input_conditioner_if.sv
// Board-side signal bundle for input_conditioner: raw switches/keys and controller
// handshake in, conditioned operand, strobe, peek level and busy flag out.
interface input_conditioner_if #(
    parameter int unsigned DATA_W = 10
);
    logic [DATA_W-1:0] SW_RAW;
    logic              KEYb_EXEC;
    logic              KEYb_PEEK;
    logic              DONE;
    logic [DATA_W-1:0] DATA;
    logic              EXEC;
    logic              Pkb;
    logic              BUSY;

    modport master (
        output SW_RAW, KEYb_EXEC, KEYb_PEEK, DONE,
        input  DATA, EXEC, Pkb, BUSY
    );

    modport slave (
        input  SW_RAW, KEYb_EXEC, KEYb_PEEK, DONE,
        output DATA, EXEC, Pkb, BUSY
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces board switches/keys, issues one EXEC strobe per press and
// freezes the DATA operand while the controller runs an instruction.
module input_conditioner #(
    parameter int unsigned DATA_W          = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input logic                CLK,
    input logic                RSTb,
    input_conditioner_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StWaitRel} state_e;

    logic [DATA_W-1:0] sw_s1_q, sw_s2_q, sw_prev_q, sw_stable_q, sw_stable_d;
    logic [CntW-1:0]   sw_cnt_q, sw_cnt_d, sw_run;
    logic              ex_s1_q, ex_s2_q, ex_stable_q, ex_stable_d;
    logic [CntW-1:0]   ex_cnt_q, ex_cnt_d;
    logic              pk_s1_q, pk_s2_q, pk_stable_q, pk_stable_d;
    logic [CntW-1:0]   pk_cnt_q, pk_cnt_d;
    logic              press_q;
    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic              exec_q, busy_q;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_prev_q   <= '0;
            sw_stable_q <= '0;
            sw_cnt_q    <= '0;
            ex_s1_q     <= 1'b1;
            ex_s2_q     <= 1'b1;
            ex_stable_q <= 1'b1;
            ex_cnt_q    <= '0;
            pk_s1_q     <= 1'b1;
            pk_s2_q     <= 1'b1;
            pk_stable_q <= 1'b1;
            pk_cnt_q    <= '0;
            press_q     <= 1'b0;
        end else begin
            sw_s1_q     <= bus.SW_RAW;
            sw_s2_q     <= sw_s1_q;
            sw_prev_q   <= sw_s2_q;
            sw_stable_q <= sw_stable_d;
            sw_cnt_q    <= sw_cnt_d;
            ex_s1_q     <= bus.KEYb_EXEC;
            ex_s2_q     <= ex_s1_q;
            ex_stable_q <= ex_stable_d;
            ex_cnt_q    <= ex_cnt_d;
            pk_s1_q     <= bus.KEYb_PEEK;
            pk_s2_q     <= pk_s1_q;
            pk_stable_q <= pk_stable_d;
            pk_cnt_q    <= pk_cnt_d;
            press_q     <= ex_stable_q & ~ex_stable_d;
        end
    end

    // A change between two non-stable switch patterns restarts the count at this cycle.
    always_comb begin
        sw_stable_d = sw_stable_q;
        sw_cnt_d    = '0;
        sw_run      = (sw_s2_q == sw_prev_q) ? sw_cnt_q : '0;
        if (sw_s2_q != sw_stable_q) begin
            if (sw_run == CntLast) begin
                sw_stable_d = sw_s2_q;
            end else begin
                sw_cnt_d = sw_run + 1'b1;
            end
        end
    end

    always_comb begin
        ex_stable_d = ex_stable_q;
        ex_cnt_d    = '0;
        if (ex_s2_q != ex_stable_q) begin
            if (ex_cnt_q == CntLast) begin
                ex_stable_d = ex_s2_q;
            end else begin
                ex_cnt_d = ex_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        pk_stable_d = pk_stable_q;
        pk_cnt_d    = '0;
        if (pk_s2_q != pk_stable_q) begin
            if (pk_cnt_q == CntLast) begin
                pk_stable_d = pk_s2_q;
            end else begin
                pk_cnt_d = pk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= StIdle;
            exec_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            exec_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (press_q) begin
                        exec_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (bus.DONE) begin
                        busy_q  <= 1'b0;
                        state_q <= ex_stable_q ? StIdle : StWaitRel;
                    end
                end
                StWaitRel: begin
                    if (ex_stable_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Operand is captured from the debounced switches only while no instruction runs.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            data_q <= '0;
        end else if (!busy_q) begin
            data_q <= sw_stable_q;
        end
    end

    assign bus.DATA = data_q;
    assign bus.EXEC = exec_q;
    assign bus.BUSY = busy_q;
    assign bus.Pkb  = pk_stable_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboarded bench for input_conditioner: a window-based reference model predicts the
// outputs after every edge, a negedge monitor compares, plus directed checks.
module tb_input_conditioner;
    localparam int D = 4;

    typedef logic [9:0] word_t;
    typedef struct packed {
        logic  exec;
        logic  busy;
        logic  pkb;
        word_t data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   n_strobe;

    input_conditioner_if #(.DATA_W(10)) bus_if ();

    input_conditioner #(
        .DATA_W         (10),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLK (clk),
        .RSTb(rst_n),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a debounced value follows its input once the last D synchronized
    // samples agree; EXEC fires on a debounced press while not busy.
    word_t sw_h[$];
    logic  ex_h[$];
    logic  pk_h[$];
    word_t m_sw_st, m_data;
    logic  m_ex_st, m_pk_st, m_press, m_busy, m_exec;
    exp_t  exp_q[$];

    task automatic model_reset();
        sw_h.delete();
        ex_h.delete();
        pk_h.delete();
        for (int i = 0; i < D + 2; i++) begin
            sw_h.push_back('0);
            ex_h.push_back(1'b1);
            pk_h.push_back(1'b1);
        end
        m_sw_st = '0;
        m_ex_st = 1'b1;
        m_pk_st = 1'b1;
        m_press = 1'b0;
        m_busy  = 1'b0;
        m_exec  = 1'b0;
        m_data  = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        word_t sw_new;
        logic  ex_new, pk_new, sw_same, ex_same, pk_same, press_new, busy_new, exec_new;
        sw_h.push_back(bus_if.SW_RAW);
        ex_h.push_back(bus_if.KEYb_EXEC);
        pk_h.push_back(bus_if.KEYb_PEEK);
        void'(sw_h.pop_front());
        void'(ex_h.pop_front());
        void'(pk_h.pop_front());
        sw_same = 1'b1;
        ex_same = 1'b1;
        pk_same = 1'b1;
        for (int i = 1; i < D; i++) begin
            sw_same &= (sw_h[i] == sw_h[0]);
            ex_same &= (ex_h[i] == ex_h[0]);
            pk_same &= (pk_h[i] == pk_h[0]);
        end
        sw_new    = sw_same ? sw_h[0] : m_sw_st;
        ex_new    = ex_same ? ex_h[0] : m_ex_st;
        pk_new    = pk_same ? pk_h[0] : m_pk_st;
        press_new = m_ex_st && !ex_new;
        exec_new  = m_press && !m_busy;
        busy_new  = exec_new ? 1'b1 : ((m_busy && bus_if.DONE) ? 1'b0 : m_busy);
        if (!m_busy) m_data = m_sw_st;
        m_exec  = exec_new;
        m_busy  = busy_new;
        m_press = press_new;
        m_sw_st = sw_new;
        m_ex_st = ex_new;
        m_pk_st = pk_new;
        exp_q.push_back('{exec: m_exec, busy: m_busy, pkb: m_pk_st, data: m_data});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus_if.EXEC) n_strobe++;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus_if.EXEC !== e.exec || bus_if.BUSY !== e.busy || bus_if.Pkb !== e.pkb ||
                    bus_if.DATA !== e.data) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got exec=%b busy=%b pkb=%b data=%h, need exec=%b busy=%b pkb=%b data=%h",
                             $time, bus_if.EXEC, bus_if.BUSY, bus_if.Pkb, bus_if.DATA,
                             e.exec, e.busy, e.pkb, e.data);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    int          s0;
    int unsigned len;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        n_strobe = 0;
        rst_n = 1'b1;
        bus_if.SW_RAW = '0;
        bus_if.KEYb_EXEC = 1'b1;
        bus_if.KEYb_PEEK = 1'b1;
        bus_if.DONE = 1'b0;

        // Reset with arbitrary inputs, before any clock edge.
        #1;
        rst_n = 1'b0;
        bus_if.SW_RAW = 10'h2AA;
        bus_if.KEYb_EXEC = 1'b0;
        bus_if.KEYb_PEEK = 1'b0;
        bus_if.DONE = 1'b1;
        #1;
        check("reset_data", bus_if.DATA, 10'h000);
        check("reset_exec", 10'(bus_if.EXEC), 10'd0);
        check("reset_busy", 10'(bus_if.BUSY), 10'd0);
        check("reset_pkb", 10'(bus_if.Pkb), 10'd1);
        bus_if.SW_RAW = '0;
        bus_if.KEYb_EXEC = 1'b1;
        bus_if.KEYb_PEEK = 1'b1;
        bus_if.DONE = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);

        // Switch bounce, then settle on 0x155.
        for (int i = 0; i < 10; i++) begin
            bus_if.SW_RAW = (i % 2 == 0) ? 10'h155 : 10'h000;
            cyc(2);
        end
        check("bounce_data", bus_if.DATA, 10'h000);
        bus_if.SW_RAW = 10'h155;
        cyc(5);
        check("settle_early", bus_if.DATA, 10'h000);
        cyc(3);
        check("settle_data", bus_if.DATA, 10'h155);

        // Held EXEC press, freeze of DATA, DONE mid-hold.
        s0 = n_strobe;
        bus_if.KEYb_EXEC = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 30) bus_if.SW_RAW = 10'h3FF;
            if (c == 50) bus_if.DONE = 1'b1;
            cyc(1);
            bus_if.DONE = 1'b0;
            if (c == 20) check("run_busy", 10'(bus_if.BUSY), 10'd1);
            if (c == 40) check("freeze_data", bus_if.DATA, 10'h155);
            if (c == 50) begin
                check("done_busy", 10'(bus_if.BUSY), 10'd0);
                check("done_data_held", bus_if.DATA, 10'h155);
            end
            if (c == 51) check("unfreeze_data", bus_if.DATA, 10'h3FF);
        end
        check("one_strobe_held", 10'(n_strobe - s0), 10'd1);
        bus_if.KEYb_EXEC = 1'b1;
        cyc(10);
        check("no_strobe_release", 10'(n_strobe - s0), 10'd1);
        bus_if.KEYb_EXEC = 1'b0;
        cyc(12);
        check("second_strobe", 10'(n_strobe - s0), 10'd2);
        bus_if.DONE = 1'b1;
        cyc(1);
        bus_if.DONE = 1'b0;
        bus_if.KEYb_EXEC = 1'b1;
        cyc(10);

        // PEEK glitch and sustained press/release.
        bus_if.KEYb_PEEK = 1'b0;
        cyc(2);
        bus_if.KEYb_PEEK = 1'b1;
        cyc(10);
        check("peek_glitch", 10'(bus_if.Pkb), 10'd1);
        bus_if.KEYb_PEEK = 1'b0;
        cyc(5);
        check("peek_press_early", 10'(bus_if.Pkb), 10'd1);
        cyc(2);
        check("peek_pressed", 10'(bus_if.Pkb), 10'd0);
        bus_if.KEYb_PEEK = 1'b1;
        cyc(5);
        check("peek_release_early", 10'(bus_if.Pkb), 10'd0);
        cyc(2);
        check("peek_released", 10'(bus_if.Pkb), 10'd1);

        // Asynchronous reset while running, key released afterwards.
        s0 = n_strobe;
        bus_if.KEYb_EXEC = 1'b0;
        cyc(10);
        check("pre_reset_busy", 10'(bus_if.BUSY), 10'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", 10'(bus_if.BUSY), 10'd0);
        check("async_data", bus_if.DATA, 10'h000);
        bus_if.KEYb_EXEC = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        check("no_strobe_after_reset", 10'(n_strobe - s0), 10'd1);

        // Key held through reset strobes once after reset.
        bus_if.KEYb_EXEC = 1'b0;
        cyc(10);
        #2;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(15);
        check("held_through_reset", 10'(n_strobe - s0), 10'd3);
        bus_if.DONE = 1'b1;
        cyc(1);
        bus_if.DONE = 1'b0;
        bus_if.KEYb_EXEC = 1'b1;
        cyc(10);

        // Randomized stimulus against the model.
        for (int seg = 0; seg < 400; seg++) begin
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 2) == 0) bus_if.SW_RAW = 10'($urandom);
            if ($urandom_range(0, 2) == 0) bus_if.KEYb_EXEC = ~bus_if.KEYb_EXEC;
            if ($urandom_range(0, 3) == 0) bus_if.KEYb_PEEK = ~bus_if.KEYb_PEEK;
            bus_if.DONE = ($urandom_range(0, 3) == 0);
            cyc(1);
            bus_if.DONE = 1'b0;
            cyc(int'(len) - 1);
        end
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
